// File: rtl/nonce_scheduler.sv
// nonce_scheduler
//   Cuts one job's nonce range into 2^CHUNK_LOG2-sized chunks and hands them
//   to idle hashing cores in round-robin order. It also merges the cores'
//   golden-nonce reports, round-robin, onto the single golden_nonce /
//   new_golden_nonce pair. The block runs in the hash_clk domain and
//   sequences job start, abort, drain and completion.
//
// Ports
//   hash_clk, reset        clock, synchronous active-high reset
//   new_work               1-cycle pulse; nonce_min/nonce_max valid with it
//   nonce_min, nonce_max   inclusive job range
//   core_idle[i]           core i can accept a chunk
//   core_start[i]          one-hot dispatch pulse; core_nonce_start/end valid
//   core_abort             1-cycle pulse: all cores drop chunk and found state
//   core_found[i]          core i holds a golden nonce (level until acked)
//   core_golden            core i nonce in bits [32*i+31:32*i]
//   core_found_ack[i]      one-hot acknowledge of a reported nonce
//   golden_nonce           last reported nonce (holds between reports)
//   new_golden_nonce       1-cycle pulse with a new golden_nonce
//   job_busy               job in DISPATCH or DRAIN
//   job_done               1-cycle pulse at job completion
//
// Optional build macro SCHED_STATS_EN adds two saturating counters:
//   chunks_issued          number of core_start pulses
//   goldens_reported       number of new_golden_nonce pulses
// Both counters are cleared by reset and by new_work.

module nonce_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int CHUNK_LOG2 = 20
) (
    input  logic                    hash_clk,
    input  logic                    reset,
    input  logic                    new_work,
    input  logic [31:0]             nonce_min,
    input  logic [31:0]             nonce_max,
    input  logic [NUM_CORES-1:0]    core_idle,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [31:0]             core_nonce_start,
    output logic [31:0]             core_nonce_end,
    output logic                    core_abort,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [32*NUM_CORES-1:0] core_golden,
    output logic [NUM_CORES-1:0]    core_found_ack,
    output logic [31:0]             golden_nonce,
    output logic                    new_golden_nonce,
    output logic                    job_busy,
    output logic                    job_done
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]             chunks_issued,
    output logic [31:0]             goldens_reported
`endif
);

    localparam int          PTR_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [32:0] CHUNK_SPAN = 33'((64'd1 << CHUNK_LOG2) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_DRAIN
    } state_t;

    // Round-robin pick: returns {hit, index} of the first request at or
    // after ptr. Scanning from the farthest offset down lets the nearest
    // request overwrite the result, so no early exit is needed.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                               input logic [PTR_W-1:0]     ptr);
        logic [PTR_W:0]   res;
        logic [PTR_W-1:0] ix;
        int               idx;
        res = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            ix = PTR_W'(idx);
            if (req[ix]) res = {1'b1, ix};
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        int t;
        t = int'(p) + 1;
        if (t >= NUM_CORES) t = 0;
        return PTR_W'(t);
    endfunction

    state_t                       state_q, state_d;
    logic [31:0]                  next_nonce_q, next_nonce_d;
    logic [31:0]                  nonce_max_q, nonce_max_d;
    logic [PTR_W-1:0]             disp_ptr_q, disp_ptr_d;
    logic [PTR_W-1:0]             found_ptr_q, found_ptr_d;
    logic [NUM_CORES-1:0]         core_start_q, core_start_d;
    logic [31:0]                  core_nonce_start_q, core_nonce_start_d;
    logic [31:0]                  core_nonce_end_q, core_nonce_end_d;
    logic                         core_abort_q, core_abort_d;
    logic                         abort_dly_q, abort_dly_d;
    logic [NUM_CORES-1:0]         core_found_ack_q, core_found_ack_d;
    logic [31:0]                  golden_nonce_q, golden_nonce_d;
    logic                         new_golden_q, new_golden_d;
    logic                         job_done_q, job_done_d;
`ifdef SCHED_STATS_EN
    logic [31:0]                  chunks_issued_q, chunks_issued_d;
    logic [31:0]                  goldens_reported_q, goldens_reported_d;
`endif

    logic [NUM_CORES-1:0][31:0]   golden_arr;
    logic [32:0]                  chunk_sum;
    logic [31:0]                  chunk_end;
    logic [PTR_W:0]               disp_pick;
    logic [PTR_W:0]               found_pick;
    logic [NUM_CORES-1:0]         found_req;

    assign golden_arr = core_golden;
    assign job_busy   = (state_q != ST_IDLE);

    always_comb begin
        state_d            = state_q;
        next_nonce_d       = next_nonce_q;
        nonce_max_d        = nonce_max_q;
        disp_ptr_d         = disp_ptr_q;
        found_ptr_d        = found_ptr_q;
        core_start_d       = '0;
        core_nonce_start_d = core_nonce_start_q;
        core_nonce_end_d   = core_nonce_end_q;
        core_abort_d       = 1'b0;
        abort_dly_d        = core_abort_q;
        core_found_ack_d   = '0;
        golden_nonce_d     = golden_nonce_q;
        new_golden_d       = 1'b0;
        job_done_d         = 1'b0;
`ifdef SCHED_STATS_EN
        chunks_issued_d    = chunks_issued_q;
        goldens_reported_d = goldens_reported_q;
`endif

        // A 33-bit sum catches the carry, so the last chunk clamps to
        // nonce_max and never wraps back to zero.
        chunk_sum = {1'b0, next_nonce_q} + CHUNK_SPAN;
        chunk_end = (chunk_sum[32] || (chunk_sum[31:0] > nonce_max_q)) ?
                    nonce_max_q : chunk_sum[31:0];

        // A core started last cycle still shows idle for one cycle.
        disp_pick = rr_pick(core_idle & ~core_start_q, disp_ptr_q);

        // Mask the core acked this cycle (its found flag is still high) and
        // mask every core for two cycles after an abort, so a report from
        // the old job cannot slip through.
        found_req  = core_found & ~core_found_ack_q &
                     {NUM_CORES{~(core_abort_q | abort_dly_q)}};
        found_pick = rr_pick(found_req, found_ptr_q);

        if (new_work) begin
            // new_work overrides any dispatch or found grant in this cycle.
            nonce_max_d  = nonce_max;
            next_nonce_d = nonce_min;
            core_abort_d = job_busy;
            if (nonce_min > nonce_max) begin
                state_d    = ST_IDLE;
                job_done_d = 1'b1;
            end else begin
                state_d = ST_DISPATCH;
            end
        end else begin
            case (state_q)
                ST_DISPATCH: begin
                    if (disp_pick[PTR_W]) begin
                        core_start_d       = NUM_CORES'(1) << disp_pick[PTR_W-1:0];
                        core_nonce_start_d = next_nonce_q;
                        core_nonce_end_d   = chunk_end;
                        next_nonce_d       = chunk_end + 32'd1;
                        disp_ptr_d         = ptr_inc(disp_pick[PTR_W-1:0]);
                        if (chunk_end == nonce_max_q) state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((&core_idle) && !(|core_found) && !(|core_start_q)) begin
                        job_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: ;
            endcase

            if (found_pick[PTR_W]) begin
                golden_nonce_d   = golden_arr[found_pick[PTR_W-1:0]];
                new_golden_d     = 1'b1;
                core_found_ack_d = NUM_CORES'(1) << found_pick[PTR_W-1:0];
                found_ptr_d      = ptr_inc(found_pick[PTR_W-1:0]);
            end
        end

`ifdef SCHED_STATS_EN
        if (new_work) begin
            chunks_issued_d    = '0;
            goldens_reported_d = '0;
        end else begin
            if ((|core_start_q) && (chunks_issued_q != 32'hFFFF_FFFF))
                chunks_issued_d = chunks_issued_q + 32'd1;
            if (new_golden_q && (goldens_reported_q != 32'hFFFF_FFFF))
                goldens_reported_d = goldens_reported_q + 32'd1;
        end
`endif
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            next_nonce_q       <= '0;
            nonce_max_q        <= '0;
            disp_ptr_q         <= '0;
            found_ptr_q        <= '0;
            core_start_q       <= '0;
            core_nonce_start_q <= '0;
            core_nonce_end_q   <= '0;
            core_abort_q       <= 1'b0;
            abort_dly_q        <= 1'b0;
            core_found_ack_q   <= '0;
            golden_nonce_q     <= '0;
            new_golden_q       <= 1'b0;
            job_done_q         <= 1'b0;
`ifdef SCHED_STATS_EN
            chunks_issued_q    <= '0;
            goldens_reported_q <= '0;
`endif
        end else begin
            state_q            <= state_d;
            next_nonce_q       <= next_nonce_d;
            nonce_max_q        <= nonce_max_d;
            disp_ptr_q         <= disp_ptr_d;
            found_ptr_q        <= found_ptr_d;
            core_start_q       <= core_start_d;
            core_nonce_start_q <= core_nonce_start_d;
            core_nonce_end_q   <= core_nonce_end_d;
            core_abort_q       <= core_abort_d;
            abort_dly_q        <= abort_dly_d;
            core_found_ack_q   <= core_found_ack_d;
            golden_nonce_q     <= golden_nonce_d;
            new_golden_q       <= new_golden_d;
            job_done_q         <= job_done_d;
`ifdef SCHED_STATS_EN
            chunks_issued_q    <= chunks_issued_d;
            goldens_reported_q <= goldens_reported_d;
`endif
        end
    end

    assign core_start       = core_start_q;
    assign core_nonce_start = core_nonce_start_q;
    assign core_nonce_end   = core_nonce_end_q;
    assign core_abort       = core_abort_q;
    assign core_found_ack   = core_found_ack_q;
    assign golden_nonce     = golden_nonce_q;
    assign new_golden_nonce = new_golden_q;
    assign job_done         = job_done_q;
`ifdef SCHED_STATS_EN
    assign chunks_issued    = chunks_issued_q;
    assign goldens_reported = goldens_reported_q;
`endif

endmodule

// File: doc/nonce_scheduler.md
Name: nonce_scheduler

Overview:
- Splits one job's nonce range into fixed-size chunks and dispatches them to NUM_CORES hashing cores, one chunk per idle core.
- Arbitrates the cores' golden-nonce reports round-robin onto the single golden_nonce/new_golden_nonce pair consumed by uart_comm.
- Lives in hash_clk domain between the UART job registers and the core array; sequences job start, abort, drain and completion.

Parameters:
- NUM_CORES, 4, number of hashing cores served (1-16).
- CHUNK_LOG2, 20, chunk size is 2^CHUNK_LOG2 nonces (0-31).

Ports:
- hash_clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- new_work  in  1  one-cycle pulse; nonce_min/nonce_max valid this cycle.
- nonce_min  in  32  first nonce of job.
- nonce_max  in  32  last nonce of job (inclusive).
- core_idle  in  NUM_CORES  core i can accept a chunk.
- core_start  out  NUM_CORES  one-hot, one-cycle dispatch pulse.
- core_nonce_start  out  32  chunk first nonce; valid with core_start.
- core_nonce_end  out  32  chunk last nonce (inclusive); valid with core_start.
- core_abort  out  1  one-cycle pulse; all cores drop current chunk and found.
- core_found  in  NUM_CORES  core i holds a golden nonce; level until acked.
- core_golden  in  32*NUM_CORES  core i nonce in bits [32*i+31:32*i].
- core_found_ack  out  NUM_CORES  one-hot, one-cycle acknowledge.
- golden_nonce  out  32  last reported nonce; holds between reports.
- new_golden_nonce  out  1  one-cycle pulse with new golden_nonce.
- job_busy  out  1  high in DISPATCH or DRAIN.
- job_done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset: all outputs 0, state IDLE, next_nonce 0, RR pointers 0.
- States: IDLE, DISPATCH, DRAIN.
- new_work in any state: latch range; if job_busy, pulse core_abort next cycle; enter DISPATCH with next_nonce=nonce_min. If nonce_min>nonce_max: no dispatch, job_done pulse next cycle, IDLE.
- DISPATCH: each cycle, grant the lowest-index idle core at or after dispatch pointer (round-robin) whose core_start was not asserted last cycle. Registered: core_start, core_nonce_start=next_nonce, core_nonce_end=min(next_nonce+2^CHUNK_LOG2-1, nonce_max). Compute with 33-bit sum; carry out clamps to nonce_max (no wrap). next_nonce advances to end+1; pointer to granted index+1 mod NUM_CORES.
- Chunk with end==nonce_max is the last: go DRAIN. Range 0..FFFFFFFF must terminate without wrap.
- DRAIN: when all core_idle high, no core_found pending, and no dispatch in last cycle -> job_done pulse, IDLE.
- Cores drop core_idle the cycle after core_start; scheduler masks just-started core for one cycle.
- Found arbitration (all states): round-robin among unmasked core_found. Grant at cycle N -> at N+1 golden_nonce=core_golden[granted], new_golden_nonce=1, core_found_ack one-hot. Granted core masked at N+1; core drops found by N+2. Max one report per cycle sustained once pointer rotates.
- core_abort cycle and following cycle: core_found fully masked, no reports (stale-job suppression).
- new_work and a grant in same cycle: new_work wins; grant discarded, no ack.
- reset mid-job: immediate IDLE, no job_done, no core_abort.

Optional Feature:
- SCHED_STATS_EN defined: adds out ports chunks_issued[31:0] (core_start count) and goldens_reported[31:0] (new_golden_nonce count); both cleared on reset and on new_work, saturating at FFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- NUM_CORES=4, CHUNK_LOG2=4, all idle, new_work 0x00000000..0x0000003F -> four starts on consecutive cycles to cores 0,1,2,3 with ranges 00-0F, 10-1F, 20-2F, 30-3F; DRAIN; job_done once all idle.
- Range 0x00000005..0x00000017 -> chunks 05-14, 15-17 (clamped); exactly 2 starts.
- Range 0xFFFFFFF8..0xFFFFFFFF -> single chunk FFFFFFF8-FFFFFFFF, no wrap, job_done.
- Range 0x10..0x0F -> no core_start, job_done one cycle after new_work.
- core_found on cores 1 and 3 same cycle, goldens 0xAAAA0001/0xBBBB0003 -> reports 0xAAAA0001 then 0xBBBB0003, one ack each, no duplicates.
- new_work during DISPATCH with core 2 found -> core_abort pulse, no report of core 2 nonce, dispatch restarts at new nonce_min.
